// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: state codes,
// datapath select codes, ALU operation codes and instruction opcode/funct values.
package mc_ctrl_fsm_pkg;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXEC    = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_BRANCH  = 3'd5;
  localparam logic [2:0] ST_JUMP    = 3'd6;
  localparam logic [2:0] ST_ILLEGAL = 3'd7;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_SUB  = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    CL_R_ALU, CL_I_ALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_ILL
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    logic [4:0]   alu_ctrl;
    logic         ext_op;
    logic         illegal;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_fsm_instr_class_dec.sv
// Combinational instruction classifier: opcode/funct -> class, ALU operation,
// immediate extension mode and an unsupported-instruction flag.
module mc_ctrl_fsm_instr_class_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CL_ILL, alu_ctrl: ALU_NOP, ext_op: 1'b0, illegal: 1'b1};
    case (opcode)
      OP_RTYPE: begin
        dec.cls     = CL_R_ALU;
        dec.illegal = 1'b0;
        case (func)
          FN_ADDU: dec.alu_ctrl = ALU_ADDU;
          FN_SUBU: dec.alu_ctrl = ALU_SUBU;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_OR:   dec.alu_ctrl = ALU_OR;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          FN_SLL:  dec.alu_ctrl = ALU_SLL;
          FN_SRL:  dec.alu_ctrl = ALU_SRL;
          FN_JR:   dec.cls      = CL_JR;
          default: begin
            dec.cls     = CL_ILL;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: dec = '{cls: CL_I_ALU, alu_ctrl: ALU_ADD,  ext_op: 1'b1, illegal: 1'b0};
      OP_SLTI: dec = '{cls: CL_I_ALU, alu_ctrl: ALU_SLT,  ext_op: 1'b1, illegal: 1'b0};
      OP_ORI:  dec = '{cls: CL_I_ALU, alu_ctrl: ALU_OR,   ext_op: 1'b0, illegal: 1'b0};
      OP_LUI:  dec = '{cls: CL_I_ALU, alu_ctrl: ALU_LUI,  ext_op: 1'b0, illegal: 1'b0};
      OP_LW:   dec = '{cls: CL_LW,    alu_ctrl: ALU_ADDU, ext_op: 1'b1, illegal: 1'b0};
      OP_SW:   dec = '{cls: CL_SW,    alu_ctrl: ALU_ADDU, ext_op: 1'b1, illegal: 1'b0};
      OP_BEQ:  dec = '{cls: CL_BEQ,   alu_ctrl: ALU_NOP,  ext_op: 1'b0, illegal: 1'b0};
      OP_BNE:  dec = '{cls: CL_BNE,   alu_ctrl: ALU_NOP,  ext_op: 1'b0, illegal: 1'b0};
      OP_J:    dec = '{cls: CL_J,     alu_ctrl: ALU_NOP,  ext_op: 1'b0, illegal: 1'b0};
      OP_JAL:  dec = '{cls: CL_JAL,   alu_ctrl: ALU_NOP,  ext_op: 1'b0, illegal: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer with held memory handshake and wait timeout.
//   state    | meaning
//   FETCH    | read instruction at PC; on mem_ready latch IR and PC <= PC+4
//   DECODE   | latch class, ALU precomputes branch target
//   EXEC     | ALU op for R/I types, address calc for LW/SW
//   MEM      | data access at ALUOut, held until mem_ready
//   WB       | register file write, instruction done
//   BRANCH   | compare rs/rt, conditional PC load, instruction done
//   JUMP     | PC load for J/JAL/JR (+ link write for JAL), instruction done
//   ILLEGAL  | flag unsupported instruction, no writes
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int ALUCTRL_W = 5,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_c,
  output logic [1:0]           pc_src,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_op,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 instr_done,
  output logic                 illegal,
  output logic                 mem_timeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(WAIT_MAX);

  logic [2:0]       state, state_nxt;
  instr_class_t     cls;
  logic [CNT_W-1:0] wait_cnt;
  dec_t             dec;
  logic             in_wait, wait_exp;
  logic [4:0]       alu_op;

  mc_ctrl_fsm_instr_class_dec u_dec (.opcode(opcode), .func(func), .dec(dec));

  assign in_wait  = (state == ST_FETCH) || (state == ST_MEM);
  // mem_ready in the terminal-count cycle still completes the access
  assign wait_exp = in_wait && !mem_ready && (wait_cnt == WAIT_TC);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec.illegal) state_nxt = ST_ILLEGAL;
        else begin
          case (dec.cls)
            CL_BEQ, CL_BNE:     state_nxt = ST_BRANCH;
            CL_J, CL_JAL, CL_JR: state_nxt = ST_JUMP;
            CL_ILL:             state_nxt = ST_ILLEGAL;
            default:            state_nxt = ST_EXEC;
          endcase
        end
      end
      ST_EXEC:   state_nxt = (cls == CL_LW || cls == CL_SW) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready)     state_nxt = (cls == CL_LW) ? ST_WB : ST_FETCH;
        else if (wait_exp) state_nxt = ST_FETCH;
      end
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      cls      <= CL_R_ALU;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) cls <= dec.cls;
      if (!in_wait || mem_ready || wait_exp) wait_cnt <= '0;
      else                                   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    pc_write_c  = 1'b0;
    pc_src      = PC_PLUS4;
    iord        = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = DST_RT;
    mem_to_reg  = WD_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    ext_op      = 1'b0;
    alu_op      = ALU_NOP;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read    = !wait_exp;
        alu_src_b   = SRCB_FOUR;
        alu_op      = ALU_ADDU;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
        mem_timeout = wait_exp;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SL2;
        ext_op    = 1'b1;
        alu_op    = ALU_ADDU;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (cls == CL_R_ALU) ? SRCB_RT : SRCB_IMM;
        ext_op    = dec.ext_op;
        alu_op    = dec.alu_ctrl;
      end
      ST_MEM: begin
        iord        = 1'b1;
        mem_read    = (cls == CL_LW) && !wait_exp;
        mem_write   = (cls == CL_SW) && !wait_exp;
        instr_done  = (cls == CL_SW) && mem_ready;
        mem_timeout = wait_exp;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls == CL_R_ALU) ? DST_RD : DST_RT;
        mem_to_reg = (cls == CL_LW) ? WD_MDR : WD_ALUOUT;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUBU;
        pc_src     = PC_BRANCH;
        pc_write_c = (cls == CL_BEQ) ? zero : !zero;
        instr_done = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = (cls == CL_JR) ? PC_RS : PC_JUMP;
        instr_done = 1'b1;
        if (cls == CL_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = DST_R31;
          mem_to_reg = WD_PC;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_ctrl = ALUCTRL_W'(alu_op);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instruction scenarios plus random instruction
// streams with random memory latency, compared cycle by cycle to a phase-level model.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  localparam int WAIT_MAX = 15;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_ILL} kind_t;
  typedef enum {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_BRANCH, P_JUMP, P_ILLEGAL} phase_t;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_t      k;
    logic [4:0] alu;
    logic       ext;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_c, iord, ir_write, mem_read, mem_write, reg_write;
  logic       alu_src_a, ext_op, instr_done, illegal, mem_timeout;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [4:0] alu_ctrl;
  logic [31:0] obs;

  int n_vec = 0;
  int n_err = 0;
  ins_t tbl[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALUCTRL_W(5), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_c(pc_write_c),
    .pc_src(pc_src), .iord(iord), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_ctrl(alu_ctrl), .instr_done(instr_done),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  assign obs = {7'b0, pc_write, pc_write_c, pc_src, iord, ir_write, mem_read, mem_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_ctrl,
                instr_done, illegal, mem_timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(logic [5:0] op, logic [5:0] fn, kind_t k, logic [4:0] alu, logic ext);
    ins_t r;
    r.op = op; r.fn = fn; r.k = k; r.alu = alu; r.ext = ext;
    return r;
  endfunction

  // Outputs required in one cycle of a given instruction phase
  function automatic logic [31:0] expect_vec(phase_t ph, ins_t in, logic rdy, logic z, logic tmo);
    logic pcw = 0, pcwc = 0, io = 0, irw = 0, mr = 0, mw = 0, rw = 0, asa = 0, ext = 0;
    logic done = 0, ill = 0, to = 0;
    logic [1:0] pcs = 2'b00, rd = 2'b00, m2r = 2'b00, asb = 2'b00;
    logic [4:0] alu = ALU_NOP;
    case (ph)
      P_FETCH: begin
        mr = !tmo; asb = 2'b01; alu = ALU_ADDU; to = tmo;
        irw = rdy; pcw = rdy;
      end
      P_DECODE: begin asb = 2'b11; ext = 1; alu = ALU_ADDU; end
      P_EXEC: begin
        asa = 1; alu = in.alu; ext = in.ext;
        asb = (in.k == K_R) ? 2'b00 : 2'b10;
      end
      P_MEM: begin
        io = 1; to = tmo;
        mr = (in.k == K_LW) && !tmo;
        mw = (in.k == K_SW) && !tmo;
        done = (in.k == K_SW) && rdy;
      end
      P_WB: begin
        rw = 1; done = 1;
        rd = (in.k == K_R) ? 2'b01 : 2'b00;
        m2r = (in.k == K_LW) ? 2'b01 : 2'b00;
      end
      P_BRANCH: begin
        asa = 1; alu = ALU_SUBU; pcs = 2'b01; done = 1;
        pcwc = (in.k == K_BEQ) ? z : !z;
      end
      P_JUMP: begin
        pcw = 1; done = 1;
        pcs = (in.k == K_JR) ? 2'b11 : 2'b10;
        if (in.k == K_JAL) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
      end
      default: ill = 1;
    endcase
    return {7'b0, pcw, pcwc, pcs, io, irw, mr, mw, rw, rd, m2r, asa, asb, ext, alu, done, ill, to};
  endfunction

  // Called just after a posedge; drives mem_ready, checks mid-cycle, moves to next edge
  task automatic cyc(input phase_t ph, input ins_t in, input logic rdy, input logic tmo, input string tag);
    mem_ready = rdy;
    #2;
    check(tag, obs, expect_vec(ph, in, rdy, zero, tmo));
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input phase_t ph, input ins_t in, input int nwait, output bit tmo_hit);
    tmo_hit = 0;
    for (int k = 0; k <= nwait && k <= WAIT_MAX; k++) begin
      if (k == nwait)         cyc(ph, in, 1'b1, 1'b0, {ph.name(), "_ready"});
      else if (k == WAIT_MAX) begin
        cyc(ph, in, 1'b0, 1'b1, {ph.name(), "_timeout"});
        tmo_hit = 1;
      end else                cyc(ph, in, 1'b0, 1'b0, {ph.name(), "_wait"});
    end
  endtask

  task automatic run_instr(input ins_t in, input logic z, input int nf, input int nm);
    bit t;
    opcode = in.op; func = in.fn; zero = z;
    mem_phase(P_FETCH, in, nf, t);
    if (t) mem_phase(P_FETCH, in, 0, t);
    cyc(P_DECODE, in, 1'($urandom), 1'b0, "decode");
    case (in.k)
      K_R, K_I: begin
        cyc(P_EXEC, in, 1'($urandom), 1'b0, "exec");
        cyc(P_WB, in, 1'($urandom), 1'b0, "wb");
      end
      K_LW: begin
        cyc(P_EXEC, in, 1'($urandom), 1'b0, "exec_lw");
        mem_phase(P_MEM, in, nm, t);
        if (!t) cyc(P_WB, in, 1'($urandom), 1'b0, "wb_lw");
      end
      K_SW: begin
        cyc(P_EXEC, in, 1'($urandom), 1'b0, "exec_sw");
        mem_phase(P_MEM, in, nm, t);
      end
      K_BEQ, K_BNE: cyc(P_BRANCH, in, 1'($urandom), 1'b0, "branch");
      K_J, K_JAL, K_JR: cyc(P_JUMP, in, 1'($urandom), 1'b0, "jump");
      default: cyc(P_ILLEGAL, in, 1'($urandom), 1'b0, "illegal");
    endcase
  endtask

  function automatic int pick_wait();
    case ($urandom_range(0, 9))
      5: return 1;
      6: return 2;
      7: return 3;
      8: return WAIT_MAX;
      9: return WAIT_MAX + 1;
      default: return 0;
    endcase
  endfunction

  initial begin
    ins_t sw_i;
    tbl.push_back(mk(6'h00, 6'h21, K_R, ALU_ADDU, 1'b0));
    tbl.push_back(mk(6'h00, 6'h23, K_R, ALU_SUBU, 1'b0));
    tbl.push_back(mk(6'h00, 6'h24, K_R, ALU_AND, 1'b0));
    tbl.push_back(mk(6'h00, 6'h25, K_R, ALU_OR, 1'b0));
    tbl.push_back(mk(6'h00, 6'h2A, K_R, ALU_SLT, 1'b0));
    tbl.push_back(mk(6'h00, 6'h00, K_R, ALU_SLL, 1'b0));
    tbl.push_back(mk(6'h00, 6'h02, K_R, ALU_SRL, 1'b0));
    tbl.push_back(mk(6'h00, 6'h08, K_JR, ALU_NOP, 1'b0));
    tbl.push_back(mk(6'h08, 6'h15, K_I, ALU_ADD, 1'b1));
    tbl.push_back(mk(6'h0A, 6'h2A, K_I, ALU_SLT, 1'b1));
    tbl.push_back(mk(6'h0D, 6'h01, K_I, ALU_OR, 1'b0));
    tbl.push_back(mk(6'h0F, 6'h3C, K_I, ALU_LUI, 1'b0));
    tbl.push_back(mk(6'h23, 6'h04, K_LW, ALU_ADDU, 1'b1));
    tbl.push_back(mk(6'h2B, 6'h10, K_SW, ALU_ADDU, 1'b1));
    tbl.push_back(mk(6'h04, 6'h00, K_BEQ, ALU_NOP, 1'b0));
    tbl.push_back(mk(6'h05, 6'h21, K_BNE, ALU_NOP, 1'b0));
    tbl.push_back(mk(6'h02, 6'h08, K_J, ALU_NOP, 1'b0));
    tbl.push_back(mk(6'h03, 6'h00, K_JAL, ALU_NOP, 1'b0));
    tbl.push_back(mk(6'h3F, 6'h00, K_ILL, ALU_NOP, 1'b0));
    tbl.push_back(mk(6'h00, 6'h3F, K_ILL, ALU_NOP, 1'b0));
    tbl.push_back(mk(6'h20, 6'h21, K_ILL, ALU_NOP, 1'b0));

    // reset: two edges low, first cycle after the first edge must look like FETCH
    rst_n = 1'b0;
    @(posedge clk); #1;
    cyc(P_FETCH, tbl[0], 1'b0, 1'b0, "reset_fetch");
    rst_n = 1'b1;

    run_instr(tbl[0], 1'b0, 0, 0);   // addu, zero-wait: 4 cycles
    run_instr(tbl[12], 1'b0, 0, 3);  // lw, 3 wait cycles in MEM: 8 cycles
    run_instr(tbl[14], 1'b1, 0, 0);  // beq taken
    run_instr(tbl[15], 1'b1, 0, 0);  // bne not taken
    run_instr(tbl[17], 1'b0, 0, 0);  // jal
    run_instr(tbl[18], 1'b0, 0, 0);  // opcode 3F
    run_instr(tbl[13], 1'b0, 0, WAIT_MAX + 1);  // sw timeout in MEM
    run_instr(tbl[8], 1'b0, WAIT_MAX + 1, 0);   // fetch timeout then refetch
    run_instr(tbl[12], 1'b0, WAIT_MAX, WAIT_MAX); // ready exactly at terminal count

    // reset in the middle of an sw memory wait
    sw_i = tbl[13];
    opcode = sw_i.op; func = sw_i.fn;
    cyc(P_FETCH, sw_i, 1'b1, 1'b0, "rst_sw_fetch");
    cyc(P_DECODE, sw_i, 1'b0, 1'b0, "rst_sw_decode");
    cyc(P_EXEC, sw_i, 1'b0, 1'b0, "rst_sw_exec");
    cyc(P_MEM, sw_i, 1'b0, 1'b0, "rst_sw_wait");
    cyc(P_MEM, sw_i, 1'b0, 1'b0, "rst_sw_wait");
    rst_n = 1'b0;
    cyc(P_MEM, sw_i, 1'b0, 1'b0, "rst_sw_hold");
    cyc(P_FETCH, sw_i, 1'b0, 1'b0, "rst_sw_fetch_after");
    rst_n = 1'b1;

    for (int i = 0; i < 250; i++)
      run_instr(tbl[$urandom_range(0, tbl.size() - 1)], 1'($urandom), pick_wait(), pick_wait());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
